// File: rtl/bexkat1_intcalc_iter_pkg.sv
// bexkat1Def: shared bexkat1 type definitions used by the integer unit.
//   intfunc_t       - T_INT/T_INTU operation codes (codes 12-15 are illegal)
//   intcalc_state_t - control states of bexkat1_intcalc_iter
// Helper functions classify an opcode as multiply, divide or signed.
package bexkat1Def;

    typedef enum logic [3:0] {
        INT_MUL   = 4'd0,
        INT_DIV   = 4'd1,
        INT_MOD   = 4'd2,
        INT_MULU  = 4'd3,
        INT_DIVU  = 4'd4,
        INT_MODU  = 4'd5,
        INT_MULX  = 4'd6,
        INT_MULUX = 4'd7,
        INT_EXT   = 4'd8,
        INT_EXTB  = 4'd9,
        INT_COM   = 4'd10,
        INT_NEG   = 4'd11
    } intfunc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } intcalc_state_t;

    function automatic logic is_mul(input logic [3:0] f);
        return (f == INT_MUL) || (f == INT_MULU) || (f == INT_MULX) || (f == INT_MULUX);
    endfunction

    function automatic logic is_div(input logic [3:0] f);
        return (f == INT_DIV) || (f == INT_DIVU) || (f == INT_MOD) || (f == INT_MODU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] f);
        return (f == INT_MUL) || (f == INT_MULX) || (f == INT_DIV) || (f == INT_MOD);
    endfunction

endpackage

// File: rtl/bexkat1_intcalc_iter_divstep.sv
// bexkat1_divstep: one combinational restoring-division step on unsigned values.
//   rem_i/quot_i  partial remainder and dividend-shift register (quotient bits
//                 enter at the bottom as dividend bits leave at the top)
//   div_i         divisor
//   rem_o/quot_o  the same pair after one step
// After WIDTH steps starting from rem=0, quot=dividend: quot=quotient, rem=remainder.
module bexkat1_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quot_i[WIDTH-1]};
        diff    = shifted - {1'b0, div_i};
        // The partial remainder is always below the divisor, so the top bit of
        // diff is a clean borrow flag.
        if (diff[WIDTH]) begin
            rem_o  = shifted[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o  = diff[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/bexkat1_intcalc_iter.sv
// bexkat1_intcalc_iter: multi-cycle integer unit for the bexkat1 T_INT/T_INTU path.
//   Iterative shift-add multiply, restoring divide (truncating), single-cycle
//   EXT/EXTB/COM/NEG. Iterations run on magnitudes; S_FIX applies signs.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i, func_i, a_i, b_i   request (accepted while ready_o=1)
//   abort_i                     synchronous flush, beats start_i
//   ready_o, valid_o            idle / one-cycle result strobe
//   result_o, result_hi_o       result (low/high product half for MUL*)
//   divzero_o                   division by zero on this result
// Configuration macro: BEXKAT1_INTCALC_FASTMUL_EN selects a single-cycle
//   multiplier registered at accept instead of the iterative one.
module bexkat1_intcalc_iter
    import bexkat1Def::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             divzero_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    intcalc_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             divzero_q, divzero_d;

    logic [3:0]       func_q, func_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier+product low / dividend+quotient

    function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? ('0 - x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign2(input logic neg,
                                                       input logic [2*WIDTH-1:0] x);
        return neg ? ('0 - x) : x;
    endfunction

    // Accept-side operand conditioning
    logic             a_sign, b_sign;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] unary_res;
    logic signed [15:0] ext_h;
    logic signed [7:0]  ext_b;

    always_comb begin
        a_sign = is_signed_op(func_i) & a_i[WIDTH-1];
        b_sign = is_signed_op(func_i) & b_i[WIDTH-1];
        mag_a  = apply_sign(a_sign, a_i);
        mag_b  = apply_sign(b_sign, b_i);
        ext_h  = a_i[15:0];
        ext_b  = a_i[7:0];
        unary_res = '0;
        case (func_i)
            INT_EXT:  unary_res = WIDTH'(ext_h);
            INT_EXTB: unary_res = WIDTH'(ext_b);
            INT_COM:  unary_res = ~a_i;
            INT_NEG:  unary_res = '0 - a_i;
            default:  unary_res = '0;
        endcase
    end

    // Iteration datapath
    logic [WIDTH-1:0] div_rem_nx, div_quot_nx;

    bexkat1_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i  (acc_hi_q),
        .quot_i (acc_lo_q),
        .div_i  (opnd_q),
        .rem_o  (div_rem_nx),
        .quot_o (div_quot_nx)
    );

`ifdef BEXKAT1_INTCALC_FASTMUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    always_comb begin
        fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    end
`else
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
`endif

    // Control: the final iteration step is folded into S_FIX together with the
    // sign fix, so S_MUL/S_DIV run WIDTH-1 cycles.
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        divzero_d   = divzero_q;
        func_d      = func_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        dz_d        = dz_q;
        opnd_d      = opnd_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        prod        = '0;

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        func_d   = func_i;
                        sa_d     = a_sign;
                        sb_d     = b_sign;
                        dz_d     = 1'b0;
                        acc_hi_d = '0;
                        if (is_mul(func_i)) begin
`ifdef BEXKAT1_INTCALC_FASTMUL_EN
                            {acc_hi_d, acc_lo_d} = fast_prod;
                            state_d = S_FIX;
`else
                            opnd_d   = mag_a;
                            acc_lo_d = mag_b;
                            cnt_d    = CNT_LOAD;
                            state_d  = S_MUL;
`endif
                        end else if (is_div(func_i)) begin
                            if (b_i == '0) begin
                                // Skip iteration; keep raw a_i for MOD/MODU.
                                dz_d     = 1'b1;
                                acc_lo_d = a_i;
                                state_d  = S_FIX;
                            end else begin
                                opnd_d   = mag_b;
                                acc_lo_d = mag_a;
                                cnt_d    = CNT_LOAD;
                                state_d  = S_DIV;
                            end
                        end else begin
                            result_d    = unary_res;
                            result_hi_d = '0;
                            divzero_d   = 1'b0;
                            state_d     = S_DONE;
                        end
                    end
                end
                S_MUL: begin
`ifndef BEXKAT1_INTCALC_FASTMUL_EN
                    acc_hi_d = mul_hi_nx;
                    acc_lo_d = mul_lo_nx;
`endif
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
                S_DIV: begin
                    acc_hi_d = div_rem_nx;
                    acc_lo_d = div_quot_nx;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d     = S_DONE;
                    divzero_d   = dz_q;
                    result_hi_d = '0;
                    if (is_mul(func_q)) begin
`ifdef BEXKAT1_INTCALC_FASTMUL_EN
                        prod = {acc_hi_q, acc_lo_q};
`else
                        prod = {mul_hi_nx, mul_lo_nx};
`endif
                        // sa/sb are already zero for the unsigned codes.
                        prod        = apply_sign2(sa_q ^ sb_q, prod);
                        result_hi_d = prod[2*WIDTH-1:WIDTH];
                        result_d    = prod[WIDTH-1:0];
                    end else if (dz_q) begin
                        result_d = ((func_q == INT_DIV) || (func_q == INT_DIVU)) ? '1 : acc_lo_q;
                    end else if ((func_q == INT_DIV) || (func_q == INT_DIVU)) begin
                        result_d = apply_sign(sa_q ^ sb_q, div_quot_nx);
                    end else begin
                        result_d = apply_sign(sa_q, div_rem_nx);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            divzero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            divzero_q   <= divzero_d;
        end
    end

    // Working registers are only read after an accept has loaded them.
    always_ff @(posedge clk_i) begin
        func_q   <= func_d;
        sa_q     <= sa_d;
        sb_q     <= sb_d;
        dz_q     <= dz_d;
        opnd_q   <= opnd_d;
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
    end

    assign ready_o     = (state_q == S_IDLE);
    assign valid_o     = (state_q == S_DONE);
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign divzero_o   = divzero_q;

endmodule

// File: tb/tb_bexkat1_intcalc_iter.sv
// Directed bench for bexkat1_intcalc_iter (WIDTH=32 instance plus a WIDTH=16
// instance for the 16-bit division corner). Expected values are hand-computed.
module tb_bexkat1_intcalc_iter;
    import bexkat1Def::*;

`ifdef BEXKAT1_INTCALC_FASTMUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32, abort32, ready32, valid32, dz32;
    logic [3:0]  func32;
    logic [31:0] a32, b32, res32, hi32;
    logic        start16, abort16, ready16, valid16, dz16;
    logic [3:0]  func16;
    logic [15:0] a16, b16, res16, hi16;

    int total = 0;
    int bad   = 0;

    bexkat1_intcalc_iter #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .func_i(func32),
        .a_i(a32), .b_i(b32), .abort_i(abort32), .ready_o(ready32),
        .valid_o(valid32), .result_o(res32), .result_hi_o(hi32), .divzero_o(dz32)
    );

    bexkat1_intcalc_iter #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .func_i(func16),
        .a_i(a16), .b_i(b16), .abort_i(abort16), .ready_o(ready16),
        .valid_o(valid16), .result_o(res16), .result_hi_o(hi16), .divzero_o(dz16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready32();
        int n = 0;
        @(negedge clk);
        while (!ready32 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one op, return latency (accept cycle -> valid cycle) and the
    // result seen one cycle after accept.
    task automatic run32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] early);
        wait_ready32();
        func32 = f; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        early = res32;
        lat = 1;
        while (!valid32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run16(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        int n = 0;
        @(negedge clk);
        while (!ready16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        func16 = f; a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 1;
        while (!valid16 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [31:0] early;

        rst = 1'b1;
        start32 = 1'b0; abort32 = 1'b0; func32 = '0; a32 = '0; b32 = '0;
        start16 = 1'b0; abort16 = 1'b0; func16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready32), 64'd1);
        chk("rst_valid", 64'(valid32), 64'd0);
        chk("rst_res",   64'(res32),   64'd0);
        chk("rst_hi",    64'(hi32),    64'd0);
        chk("rst_dz",    64'(dz32),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Signed divide family
        run32(INT_DIV, 32'hFFFFFFF9, 32'd2, lat, early);
        chk("div_q",   64'(res32), 64'hFFFFFFFD);
        chk("div_lat", 64'(lat),   64'd33);
        chk("div_dz",  64'(dz32),  64'd0);
        chk("div_hi",  64'(hi32),  64'd0);
        run32(INT_MOD, 32'hFFFFFFF9, 32'd2, lat, early);
        chk("mod_r",    64'(res32), 64'hFFFFFFFF);
        chk("mod_dz",   64'(dz32),  64'd0);
        chk("mod_hold", 64'(early), 64'hFFFFFFFD);
        run32(INT_DIV, 32'd7, 32'hFFFFFFFE, lat, early);
        chk("div_pos_neg", 64'(res32), 64'hFFFFFFFD);
        run32(INT_MOD, 32'd7, 32'hFFFFFFFE, lat, early);
        chk("mod_pos_neg", 64'(res32), 64'd1);
        run32(INT_DIV, 32'h80000000, 32'hFFFFFFFF, lat, early);
        chk("div_min_m1", 64'(res32), 64'h80000000);
        run32(INT_MOD, 32'h80000000, 32'hFFFFFFFF, lat, early);
        chk("mod_min_m1", 64'(res32), 64'd0);
        run32(INT_DIVU, 32'd100, 32'd7, lat, early);
        chk("divu", 64'(res32), 64'd14);
        run32(INT_MODU, 32'd100, 32'd7, lat, early);
        chk("modu", 64'(res32), 64'd2);

        // Divide by zero
        run32(INT_DIVU, 32'h10, 32'd0, lat, early);
        chk("divu0_res", 64'(res32), 64'hFFFFFFFF);
        chk("divu0_dz",  64'(dz32),  64'd1);
        chk("divu0_lat", 64'(lat),   64'd2);
        run32(INT_MODU, 32'h10, 32'd0, lat, early);
        chk("modu0_res",  64'(res32), 64'h10);
        chk("modu0_dz",   64'(dz32),  64'd1);
        chk("modu0_lat",  64'(lat),   64'd2);
        chk("modu0_hold", 64'(early), 64'hFFFFFFFF);
        run32(INT_MOD, 32'hFFFFFFF0, 32'd0, lat, early);
        chk("mod0_res", 64'(res32), 64'hFFFFFFF0);

        // Unary ops
        run32(INT_EXTB, 32'h00000080, 32'd0, lat, early);
        chk("extb_res", 64'(res32), 64'hFFFFFF80);
        chk("extb_lat", 64'(lat),   64'd1);
        chk("extb_dz",  64'(dz32),  64'd0);
        run32(INT_EXT, 32'h12348001, 32'd0, lat, early);
        chk("ext_neg", 64'(res32), 64'hFFFF8001);
        run32(INT_EXT, 32'hFFFF7FFF, 32'd0, lat, early);
        chk("ext_pos", 64'(res32), 64'h00007FFF);
        run32(INT_COM, 32'h0F0F0000, 32'd0, lat, early);
        chk("com", 64'(res32), 64'hF0F0FFFF);
        run32(4'd12, 32'h12345678, 32'd3, lat, early);
        chk("illegal12",     64'(res32), 64'd0);
        chk("illegal12_lat", 64'(lat),   64'd1);

        // Multiplies
        run32(INT_MULX, 32'hFFFFFFFF, 32'd2, lat, early);
        chk("mulx_hi",  64'(hi32),  64'hFFFFFFFF);
        chk("mulx_lo",  64'(res32), 64'hFFFFFFFE);
        chk("mulx_lat", 64'(lat),   64'(MUL_LAT));
        run32(INT_MULUX, 32'hFFFFFFFF, 32'd2, lat, early);
        chk("mulux_hi",  64'(hi32),  64'd1);
        chk("mulux_lo",  64'(res32), 64'hFFFFFFFE);
        chk("mulux_lat", 64'(lat),   64'(MUL_LAT));
        run32(INT_MUL, 32'hFFFFFFFD, 32'd5, lat, early);
        chk("mul_neg", {hi32, res32}, 64'hFFFFFFFF_FFFFFFF1);
        run32(INT_MUL, 32'h12345678, 32'h10, lat, early);
        chk("mul_pos", {hi32, res32}, 64'h00000001_23456780);
        run32(INT_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, early);
        chk("mulu_max", {hi32, res32}, 64'hFFFFFFFE_00000001);
        run32(INT_NEG, 32'd1, 32'd0, lat, early);
        chk("neg_clears_hi", 64'(hi32), 64'd0);

        // Back-to-back with start_i held high
        wait_ready32();
        func32 = INT_EXTB; a32 = 32'h80; b32 = '0; start32 = 1'b1;
        @(posedge clk); #1;
        chk("b2b_v1",    64'(valid32), 64'd1);
        chk("b2b_res",   64'(res32),   64'hFFFFFF80);
        @(posedge clk); #1;
        chk("b2b_gap",   64'(valid32), 64'd0);
        chk("b2b_ready", 64'(ready32), 64'd1);
        @(posedge clk); #1;
        chk("b2b_v2",    64'(valid32), 64'd1);
        start32 = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end",   64'(valid32), 64'd0);

        // abort_i with start_i while idle: start dropped
        wait_ready32();
        func32 = INT_NEG; a32 = 32'd1; start32 = 1'b1; abort32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; abort32 = 1'b0;
        chk("abort_start_ready", 64'(ready32), 64'd1);
        @(posedge clk); #1;
        chk("abort_start_valid", 64'(valid32), 64'd0);
        chk("abort_start_res",   64'(res32),   64'hFFFFFF80);

        // abort_i 10 cycles into a DIV
        wait_ready32();
        func32 = INT_DIV; a32 = 32'd100; b32 = 32'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        seen = 0;
        repeat (9) begin
            @(posedge clk); #1;
            if (valid32) seen = 1;
        end
        chk("abort_busy", 64'(ready32), 64'd0);
        @(negedge clk);
        abort32 = 1'b1;
        @(posedge clk); #1;
        abort32 = 1'b0;
        chk("abort_ready", 64'(ready32), 64'd1);
        chk("abort_valid", 64'(valid32), 64'd0);
        chk("abort_res",   64'(res32),   64'hFFFFFF80);
        repeat (40) begin
            @(posedge clk); #1;
            if (valid32) seen = 1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        run32(INT_NEG, 32'd5, 32'd0, lat, early);
        chk("neg_after_abort", 64'(res32), 64'hFFFFFFFB);

        // Reset in the middle of a multiply
        run32(INT_MULUX, 32'hFFFFFFFF, 32'd2, lat, early);
        wait_ready32();
        func32 = INT_MULX; a32 = 32'hFFFFFFFF; b32 = 32'd2; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        chk("rstmid_busy", 64'(ready32), 64'd0);
        rst = 1'b1;
        #1;
        chk("rstmid_res",   64'(res32),   64'd0);
        chk("rstmid_hi",    64'(hi32),    64'd0);
        chk("rstmid_ready", 64'(ready32), 64'd1);
        chk("rstmid_valid", 64'(valid32), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=16 signed division corner
        run16(INT_DIV, 16'h8000, 16'hFFFF, lat);
        chk("w16_div",     64'(res16), 64'h8000);
        chk("w16_div_lat", 64'(lat),   64'd17);
        chk("w16_div_dz",  64'(dz16),  64'd0);
        run16(INT_MOD, 16'h8000, 16'hFFFF, lat);
        chk("w16_mod",     64'(res16), 64'h0000);
        chk("w16_mod_hi",  64'(hi16),  64'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
